// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: round-robin duty arbiter that ramps the PWM duty one STEP per frame on frame boundaries
module pwm_duty_sequencer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int PWM_HZ   = 50,
  parameter int DUTY_MAX = 100,
  parameter int STEP     = 1,
  parameter int DUTY_RST = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [6:0] a_duty,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_duty,
  output logic       b_ready,
  output logic [6:0] duty,
  output logic       frame_start,
  output logic       busy,
  output logic       done,
  output logic       clamped,
  output logic       last_b
);
  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(PERIOD - 1);
  localparam logic [6:0] L_MAX = 7'(DUTY_MAX);
  localparam logic [6:0] L_STEP = 7'(STEP);
  localparam logic [6:0] L_RST = 7'(DUTY_RST);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [6:0] r_duty, r_target, w_cmd, w_tgt, w_diff;
  logic r_fs, r_done, r_clamped, r_last_b, w_grant_b, w_hs, w_up, w_idle;
  always_comb begin
    w_cnt_nxt = (r_cnt == L_LAST) ? '0 : r_cnt + CW'(1);
    w_idle    = (r_state == IDLE);
    w_grant_b = b_valid & (~a_valid | ~r_last_b);
    w_hs      = w_idle & (a_valid | b_valid);
    w_cmd     = w_grant_b ? b_duty : a_duty;
    w_tgt     = (w_cmd > L_MAX) ? L_MAX : w_cmd;
    w_up      = r_target > r_duty;
    w_diff    = w_up ? r_target - r_duty : r_duty - r_target;
  end
  assign a_ready     = w_idle & a_valid & ~w_grant_b;
  assign b_ready     = w_idle & w_grant_b;
  assign duty        = r_duty;
  assign frame_start = r_fs;
  assign busy        = (r_state == RAMP);
  assign done        = r_done;
  assign clamped     = r_clamped;
  assign last_b      = r_last_b;
  // frame_start is registered one count early so it is high while the counter sits at PERIOD-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_fs      <= 1'b0;
      r_duty    <= L_RST;
      r_target  <= L_RST;
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_clamped <= 1'b0;
      r_last_b  <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_fs      <= (w_cnt_nxt == L_LAST);
      r_done    <= 1'b0;
      r_clamped <= 1'b0;
      if (r_state == IDLE) begin
        if (w_hs) begin
          r_last_b  <= w_grant_b;
          r_target  <= w_tgt;
          r_clamped <= (w_cmd > L_MAX);
          if (w_tgt == r_duty) r_done <= 1'b1;
          else r_state <= RAMP;
        end
      end else if (r_fs) begin
        if (w_diff <= L_STEP) begin
          r_duty  <= r_target;
          r_state <= IDLE;
          r_done  <= 1'b1;
        end else begin
          r_duty <= w_up ? r_duty + L_STEP : r_duty - L_STEP;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed checks of reset, framing, arbitration, ramping, clamping and mid-ramp reset
module tb_pwm_duty_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, b7_valid = 1'b0;
  logic [6:0] a_duty = '0, b_duty = '0, b7_duty = '0;
  logic a_ready, b_ready, fs, busy, done, clamped, last_b;
  logic [6:0] duty;
  logic a7_ready, b7_ready, fs7, busy7, done7, clamped7, last_b7;
  logic [6:0] duty7;
  int checks = 0, errs = 0;
  always #5 clk = ~clk;
  pwm_duty_sequencer #(.CLK_HZ(1000), .PWM_HZ(100), .DUTY_MAX(100), .STEP(1), .DUTY_RST(7)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_duty(a_duty), .a_ready(a_ready),
    .b_valid(b_valid), .b_duty(b_duty), .b_ready(b_ready), .duty(duty), .frame_start(fs),
    .busy(busy), .done(done), .clamped(clamped), .last_b(last_b));
  pwm_duty_sequencer #(.CLK_HZ(1000), .PWM_HZ(100), .DUTY_MAX(100), .STEP(7), .DUTY_RST(95)) dut7 (
    .clk(clk), .rst(rst), .a_valid(1'b0), .a_duty(7'd0), .a_ready(a7_ready),
    .b_valid(b7_valid), .b_duty(b7_duty), .b_ready(b7_ready), .duty(duty7), .frame_start(fs7),
    .busy(busy7), .done(done7), .clamped(clamped7), .last_b(last_b7));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_fs();
    int n;
    n = 0;
    while (!fs && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!fs) chk("fs_timeout", 0, 1);
  endtask
  task automatic wait_done(output int mn);
    int n;
    n = 0;
    mn = duty;
    while (!done && n < 300) begin
      @(negedge clk);
      if (duty < mn) mn = duty;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int c, first, second, mn;
    first = 0;
    second = 0;
    repeat (2) @(negedge clk);
    chk("rst_duty", duty, 7);
    chk("rst_busy", busy, 0);
    chk("rst_last_b", last_b, 1);
    chk("rst_fs", fs, 0);
    chk("rst_duty7", duty7, 95);
    rst = 1'b0;
    #1;
    c = 1;
    while (second == 0 && c < 40) begin
      if (fs && first == 0) first = c;
      else if (fs) second = c;
      if (second == 0) begin
        @(negedge clk);
        c++;
      end
    end
    chk("fs_first_cycle", first, 10);
    chk("fs_second_cycle", second, 20);
    a_valid = 1'b1;
    a_duty = 7'd10;
    #1;
    chk("a_ready_t2", a_ready, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    chk("hs_on_fs_hold", duty, 7);
    chk("busy_t2", busy, 1);
    chk("last_b_t2", last_b, 0);
    chk("a_ready_ramp", a_ready, 0);
    wait_fs();
    @(negedge clk);
    chk("step_8", duty, 8);
    wait_fs();
    @(negedge clk);
    chk("step_9", duty, 9);
    chk("no_early_done", done, 0);
    wait_fs();
    @(negedge clk);
    chk("step_10", duty, 10);
    chk("done_t2", done, 1);
    chk("busy_end_t2", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    do_reset();
    a_valid = 1'b1;
    a_duty = 7'd20;
    b_valid = 1'b1;
    b_duty = 7'd3;
    #1;
    chk("contend_a_ready", a_ready, 1);
    chk("contend_b_ready", b_ready, 0);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    chk("b_wait_ready", b_ready, 0);
    chk("last_b_after_a", last_b, 0);
    wait_done(mn);
    chk("a_reached", duty, 20);
    chk("b_served", b_ready, 1);
    @(posedge clk);
    #1 b_valid = 1'b0;
    @(negedge clk);
    chk("last_b_after_b", last_b, 1);
    chk("busy_down", busy, 1);
    wait_done(mn);
    chk("b_reached", duty, 3);
    chk("no_undershoot", mn, 3);
    do_reset();
    a_valid = 1'b1;
    a_duty = 7'd7;
    #1;
    chk("eq_a_ready", a_ready, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_duty", duty, 7);
    chk("eq_clamped", clamped, 0);
    do_reset();
    a_valid = 1'b1;
    a_duty = 7'd20;
    #1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    wait_fs();
    @(negedge clk);
    wait_fs();
    @(negedge clk);
    chk("mid_duty_9", duty, 9);
    #2 rst = 1'b1;
    #1;
    chk("async_duty", duty, 7);
    chk("async_busy", busy, 0);
    chk("async_fs", fs, 0);
    mn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) mn++;
    end
    chk("no_done_on_rst", mn, 0);
    rst = 1'b0;
    a_valid = 1'b1;
    a_duty = 7'd5;
    #1;
    chk("ready_after_rst", a_ready, 1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    do_reset();
    b7_valid = 1'b1;
    b7_duty = 7'd120;
    #1;
    chk("b7_ready", b7_ready, 1);
    @(posedge clk);
    #1 b7_valid = 1'b0;
    @(negedge clk);
    chk("clamped_pulse", clamped7, 1);
    chk("busy7", busy7, 1);
    chk("duty7_hold", duty7, 95);
    @(negedge clk);
    chk("clamped_one_cycle", clamped7, 0);
    wait_fs();
    @(negedge clk);
    chk("duty7_clamped_100", duty7, 100);
    chk("done7", done7, 1);
    chk("busy7_end", busy7, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Controller that sequences the duty-cycle input of the PWM generator.
- Arbitrates between two duty-command requesters (A: push-button/manual path, B: automatic/sweep path) using round-robin.
- Ramps the applied duty toward the accepted target by STEP percent per PWM frame.
- Changes duty only on a frame boundary, so a PWM period never sees a mid-period duty glitch.
- Sits between the requesters and the PWM comparator; it owns the frame counter and exports the frame-aligned duty.

Parameters:
- CLK_HZ, 50_000_000, base clock frequency.
- PWM_HZ, 50, PWM frame rate. PERIOD = CLK_HZ/PWM_HZ clocks per frame (must be >= 2).
- DUTY_MAX, 100, maximum duty in percent.
- STEP, 1, duty change per frame while ramping (1..DUTY_MAX).
- DUTY_RST, 7, duty value loaded on reset.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-high reset.
- a_valid, input, 1, requester A has a target.
- a_duty, input, 7, requester A target in percent.
- a_ready, output, 1, A command accepted this cycle when a_valid is also high.
- b_valid, input, 1, requester B has a target.
- b_duty, input, 7, requester B target in percent.
- b_ready, output, 1, B command accepted this cycle when b_valid is also high.
- duty, output, 7, applied duty, for the PWM comparator.
- frame_start, output, 1, one-cycle pulse on the last clock of each frame.
- busy, output, 1, ramp in progress.
- done, output, 1, one-cycle pulse when duty reaches target.
- clamped, output, 1, one-cycle pulse when an accepted target exceeded DUTY_MAX.
- last_b, output, 1, requester of the most recent grant (1 = B).

Behaviour:
- Reset is asynchronous, active-high, on rst, with clock clk.
  - Reset values: frame counter 0, duty = DUTY_RST, target = DUTY_RST, state IDLE, busy 0, done 0, clamped 0, frame_start 0, last_b 1 (so A wins the first contention).
  - Reset mid-ramp abandons the target immediately; no done pulse.
- Frame counter:
  - Counts 0..PERIOD-1, then wraps to 0.
  - frame_start is registered and high exactly when the counter equals PERIOD-1; one pulse every PERIOD clocks.
  - The first pulse occurs PERIOD cycles after reset release.
- Arbitration (combinational grant, evaluated only in IDLE):
  - Only one valid: that requester is granted.
  - Both valid: grant B if last_b = 0, else grant A.
  - a_ready = IDLE & grant_a; b_ready = IDLE & grant_b. Ready is 0 in RAMP.
  - A handshake is valid & ready in the same cycle; the requester holds valid and duty until it sees ready.
  - On handshake, last_b updates to the granted source.
- FSM states: IDLE and RAMP.
  - IDLE, on handshake:
    - Load target = min(cmd, DUTY_MAX); pulse clamped next cycle if cmd > DUTY_MAX.
    - If target == duty: stay IDLE, pulse done next cycle.
    - Else go to RAMP; busy = 1 from the next cycle.
  - RAMP, on each frame_start cycle:
    - If |target - duty| <= STEP: duty <= target, go to IDLE, done pulse next cycle.
    - Else duty moves STEP toward target (up if target > duty, down otherwise).
  - RAMP with no frame_start: duty holds.
- Arithmetic and timing:
  - Duty never leaves 0..DUTY_MAX and never overshoots target.
  - Ramp length is ceil(|target - duty| / STEP) frames.
  - duty changes only on the clock edge ending a frame_start cycle.
  - A handshake in the same cycle as frame_start does not move duty until the next frame_start.
- New commands are not accepted during RAMP. A requester left valid is served in IDLE on the first cycle after the done pulse is issued.
- busy = (state == RAMP).

Test Plan:
1. Reset, PERIOD=10 (CLK_HZ=1000, PWM_HZ=100) -> duty=7, busy=0, last_b=1, frame_start first high 10 cycles after rst falls, then every 10 cycles.
2. A sends 10, STEP=1 -> a_ready same cycle; duty steps 8, 9, 10 on three consecutive frame_starts; done one cycle after duty=10; busy low thereafter.
3. A and B both valid (A=20, B=3) at reset state -> A granted first (last_b→0); after A's done, B granted; duty ramps down to 3 with no overshoot.
4. B sends 120 -> clamped pulse, target=100; with STEP=7 from duty=95, duty goes 100 in one frame, then done.
5. Command equal to current duty (7) -> immediate done, no busy, duty unchanged.
6. rst asserted mid-ramp (duty=9 toward 20) -> duty=7 asynchronously, IDLE, counter 0, no done pulse; ready reasserts after release.
